// File: rtl/idu_pkg.sv
// rtl/idu_pkg.sv - RV32I decode constants, op/format enums and the decoded-entry record
package idu_pkg;

  localparam logic [6:0] OPC_R_ALU  = 7'b0110011;
  localparam logic [6:0] OPC_I_ALU  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_ENV    = 7'b1110011;

  typedef enum logic [5:0] {
    OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND,
    OP_ADDI, OP_SLTI, OP_SLTIU, OP_XORI, OP_ORI, OP_ANDI, OP_SLLI, OP_SRLI, OP_SRAI,
    OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU,
    OP_SB, OP_SH, OP_SW,
    OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU,
    OP_JAL, OP_JALR, OP_LUI, OP_AUIPC, OP_ECALL, OP_EBREAK,
    OP_ILLEGAL
  } op_e;

  typedef enum logic [2:0] {IMM_R, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_fmt_e;

  // Width-independent part of a decoded entry; imm and pc travel alongside.
  typedef struct packed {
    op_e        op;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       rd_we;
    logic       illegal;
  } dec_t;

endpackage

// File: rtl/idu_decode.sv
// rtl/idu_decode.sv - combinational RV32I decode: op, register fields, immediate, rd write enable
module idu_decode
  import idu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     inst_i,
  output dec_t            dec_o,
  output logic [XLEN-1:0] imm_o
);

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  op_e         op;
  imm_fmt_e    fmt;
  logic        writes;
  logic        illegal;
  logic [31:0] imm32;

  assign opcode = inst_i[6:0];
  assign funct3 = inst_i[14:12];
  assign funct7 = inst_i[31:25];
  assign rd     = inst_i[11:7];
  assign rs1    = inst_i[19:15];

  always_comb begin
    op     = OP_ILLEGAL;
    fmt    = IMM_R;
    writes = 1'b0;
    case (opcode)
      OPC_R_ALU: begin
        writes = 1'b1;
        case ({funct7, funct3})
          {7'h00, 3'h0}: op = OP_ADD;
          {7'h20, 3'h0}: op = OP_SUB;
          {7'h00, 3'h1}: op = OP_SLL;
          {7'h00, 3'h2}: op = OP_SLT;
          {7'h00, 3'h3}: op = OP_SLTU;
          {7'h00, 3'h4}: op = OP_XOR;
          {7'h00, 3'h5}: op = OP_SRL;
          {7'h20, 3'h5}: op = OP_SRA;
          {7'h00, 3'h6}: op = OP_OR;
          {7'h00, 3'h7}: op = OP_AND;
          default:       op = OP_ILLEGAL;
        endcase
      end
      OPC_I_ALU: begin
        fmt    = IMM_I;
        writes = 1'b1;
        case (funct3)
          3'h0: op = OP_ADDI;
          3'h2: op = OP_SLTI;
          3'h3: op = OP_SLTIU;
          3'h4: op = OP_XORI;
          3'h6: op = OP_ORI;
          3'h7: op = OP_ANDI;
          3'h1: op = (funct7 == 7'h00) ? OP_SLLI : OP_ILLEGAL;
          default: op = (funct7 == 7'h00) ? OP_SRLI :
                        (funct7 == 7'h20) ? OP_SRAI : OP_ILLEGAL;
        endcase
      end
      OPC_LOAD: begin
        fmt    = IMM_I;
        writes = 1'b1;
        case (funct3)
          3'h0: op = OP_LB;
          3'h1: op = OP_LH;
          3'h2: op = OP_LW;
          3'h4: op = OP_LBU;
          3'h5: op = OP_LHU;
          default: op = OP_ILLEGAL;
        endcase
      end
      OPC_STORE: begin
        fmt = IMM_S;
        case (funct3)
          3'h0: op = OP_SB;
          3'h1: op = OP_SH;
          3'h2: op = OP_SW;
          default: op = OP_ILLEGAL;
        endcase
      end
      OPC_BRANCH: begin
        fmt = IMM_B;
        case (funct3)
          3'h0: op = OP_BEQ;
          3'h1: op = OP_BNE;
          3'h4: op = OP_BLT;
          3'h5: op = OP_BGE;
          3'h6: op = OP_BLTU;
          3'h7: op = OP_BGEU;
          default: op = OP_ILLEGAL;
        endcase
      end
      OPC_JAL: begin
        fmt    = IMM_J;
        writes = 1'b1;
        op     = OP_JAL;
      end
      OPC_JALR: begin
        fmt    = IMM_I;
        writes = 1'b1;
        op     = (funct3 == 3'h0) ? OP_JALR : OP_ILLEGAL;
      end
      OPC_LUI: begin
        fmt    = IMM_U;
        writes = 1'b1;
        op     = OP_LUI;
      end
      OPC_AUIPC: begin
        fmt    = IMM_U;
        writes = 1'b1;
        op     = OP_AUIPC;
      end
      OPC_ENV: begin
        // Only the two exact encodings are legal: all fields zero except imm[0].
        if (funct3 == 3'h0 && rs1 == 5'd0 && rd == 5'd0 && inst_i[31:21] == 11'd0)
          op = inst_i[20] ? OP_EBREAK : OP_ECALL;
      end
      default: op = OP_ILLEGAL;
    endcase
    illegal = (op == OP_ILLEGAL) || (inst_i[1:0] != 2'b11);
    if (illegal) begin
      op     = OP_ILLEGAL;
      fmt    = IMM_R;
      writes = 1'b0;
    end
  end

  always_comb begin
    case (fmt)
      IMM_I:   imm32 = {{20{inst_i[31]}}, inst_i[31:20]};
      IMM_S:   imm32 = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
      IMM_B:   imm32 = {{19{inst_i[31]}}, inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
      IMM_U:   imm32 = {inst_i[31:12], 12'd0};
      IMM_J:   imm32 = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};
      default: imm32 = 32'd0;
    endcase
  end

  assign imm_o         = XLEN'($signed(imm32));
  assign dec_o.op      = op;
  assign dec_o.rd      = rd;
  assign dec_o.rs1     = rs1;
  assign dec_o.rs2     = inst_i[24:20];
  assign dec_o.rd_we   = writes && (rd != 5'd0);
  assign dec_o.illegal = illegal;

endmodule

// File: rtl/idu_stage.sv
// rtl/idu_stage.sv - registered decode stage: main output register plus one skid entry
module idu_stage
  import idu_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int OP_WIDTH = 6,
  parameter int NR_OP    = 40
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [31:0]         in_inst,
  input  logic [XLEN-1:0]     in_pc,
  input  logic                flush,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [OP_WIDTH-1:0] out_op,
  output logic [4:0]          out_rd,
  output logic [4:0]          out_rs1,
  output logic [4:0]          out_rs2,
  output logic [XLEN-1:0]     out_imm,
  output logic [XLEN-1:0]     out_pc,
  output logic                out_rd_we,
  output logic                out_illegal
);

  if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
    $error("idu_stage: XLEN must be 32 or 64");
  end
  if (OP_WIDTH < $clog2(NR_OP)) begin : g_bad_op_width
    $error("idu_stage: OP_WIDTH too narrow for NR_OP");
  end

  dec_t            dec;
  logic [XLEN-1:0] dec_imm;

  idu_decode #(.XLEN(XLEN)) u_decode (
    .inst_i (in_inst),
    .dec_o  (dec),
    .imm_o  (dec_imm)
  );

  logic            main_valid_q, main_valid_d;
  logic            skid_valid_q, skid_valid_d;
  logic            ready_q, ready_d;
  dec_t            main_dec_q, main_dec_d, skid_dec_q, skid_dec_d;
  logic [XLEN-1:0] main_imm_q, main_imm_d, skid_imm_q, skid_imm_d;
  logic [XLEN-1:0] main_pc_q, main_pc_d, skid_pc_q, skid_pc_d;
  logic            accept;
  logic            drain;

  assign accept = in_valid && ready_q;
  assign drain  = main_valid_q && out_ready;

  always_comb begin
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    main_dec_d   = main_dec_q;
    main_imm_d   = main_imm_q;
    main_pc_d    = main_pc_q;
    skid_dec_d   = skid_dec_q;
    skid_imm_d   = skid_imm_q;
    skid_pc_d    = skid_pc_q;
    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (skid_valid_q) begin
      // ready_q is low here, so the only event is the skid entry advancing.
      if (drain) begin
        main_dec_d   = skid_dec_q;
        main_imm_d   = skid_imm_q;
        main_pc_d    = skid_pc_q;
        skid_valid_d = 1'b0;
      end
    end else if (!main_valid_q || drain) begin
      main_valid_d = accept;
      if (accept) begin
        main_dec_d = dec;
        main_imm_d = dec_imm;
        main_pc_d  = in_pc;
      end
    end else if (accept) begin
      skid_valid_d = 1'b1;
      skid_dec_d   = dec;
      skid_imm_d   = dec_imm;
      skid_pc_d    = in_pc;
    end
    ready_d = !skid_valid_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      ready_q      <= 1'b1;
      main_dec_q   <= '0;
      main_imm_q   <= '0;
      main_pc_q    <= '0;
      skid_dec_q   <= '0;
      skid_imm_q   <= '0;
      skid_pc_q    <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      ready_q      <= ready_d;
      main_dec_q   <= main_dec_d;
      main_imm_q   <= main_imm_d;
      main_pc_q    <= main_pc_d;
      skid_dec_q   <= skid_dec_d;
      skid_imm_q   <= skid_imm_d;
      skid_pc_q    <= skid_pc_d;
    end
  end

  assign in_ready    = ready_q;
  assign out_valid   = main_valid_q;
  assign out_op      = OP_WIDTH'(main_dec_q.op);
  assign out_rd      = main_dec_q.rd;
  assign out_rs1     = main_dec_q.rs1;
  assign out_rs2     = main_dec_q.rs2;
  assign out_imm     = main_imm_q;
  assign out_pc      = main_pc_q;
  assign out_rd_we   = main_dec_q.rd_we;
  assign out_illegal = main_dec_q.illegal;

endmodule
